// File: rtl/single_mdu_pkg.sv
// Shared definitions for the single-cycle-issue multiply/divide unit.
// The op encoding, FSM states and datapath constants live here.
package single_mdu_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;

    localparam logic [4:0]      CNT_LOAD = 5'(ITER_COUNT - 1);
    localparam logic [XLEN-1:0] DIV0_LO  = 32'hFFFF_FFFF;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_divider.sv
// One restoring shift-subtract divide step on unsigned magnitudes.
// Exists only in builds with MDU_DIV_EN defined.
`ifdef MDU_DIV_EN
module mdu_divider
    import single_mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic          fits;

    // The partial remainder is always below the divisor, so a successful
    // subtraction always fits back into XLEN bits.
    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        fits    = (shifted >= {1'b0, divisor});
        rem_out = fits ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
        quo_out = {quo_in[XLEN-2:0], fits};
    end

endmodule
`endif

// File: rtl/single_mdu.sv
// Iterative HI/LO multiply/divide unit: 32 radix-2 steps plus one commit cycle.
// Define MDU_DIV_EN to build the DIV/DIVU datapath; otherwise they are no-ops.
module single_mdu
    import single_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs,
    input  logic [XLEN-1:0] i_rt,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    state_t              state;
    logic [4:0]          count;
    logic                done;
    logic [XLEN-1:0]     hi;
    logic [XLEN-1:0]     lo;

    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     mcand;
    logic                neg_lo;

    logic                calc_op;
    logic                signed_op;
    logic                accept;
    logic signed [XLEN-1:0] rs_s;
    logic signed [XLEN-1:0] rt_s;
    logic [XLEN-1:0]     rs_mag;
    logic [XLEN-1:0]     rt_mag;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   acc_next;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     res_hi;
    logic [XLEN-1:0]     res_lo;

`ifdef MDU_DIV_EN
    logic                div_op;
    logic                is_div;
    logic                neg_hi;
    logic                div_zero;
    logic [XLEN-1:0]     rs_raw;
    logic [XLEN-1:0]     div_rem;
    logic [XLEN-1:0]     div_quo;
`endif

    function automatic logic [XLEN-1:0] cond_neg32(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg64(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    assign rs_s = i_rs;
    assign rt_s = i_rt;

    always_comb begin
        calc_op   = (i_op == OP_MULT) || (i_op == OP_MULTU);
        signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
`ifdef MDU_DIV_EN
        div_op    = (i_op == OP_DIV) || (i_op == OP_DIVU);
        if (div_op) calc_op = 1'b1;
`endif
    end

    assign accept = (state == ST_IDLE) && i_start && calc_op;
    assign rs_mag = cond_neg32(i_rs, signed_op && (rs_s < 0));
    assign rt_mag = cond_neg32(i_rt, signed_op && (rt_s < 0));

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        acc_next = {mul_sum, acc[XLEN-1:1]};
`ifdef MDU_DIV_EN
        if (is_div) acc_next = {div_rem, div_quo};
`endif
    end

`ifdef MDU_DIV_EN
    mdu_divider u_divider (
        .rem_in  (acc[2*XLEN-1:XLEN]),
        .quo_in  (acc[XLEN-1:0]),
        .divisor (mcand),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );
`endif

    // Sign correction applied only on the commit edge.
    always_comb begin
        prod   = cond_neg64(acc, neg_lo);
        res_hi = prod[2*XLEN-1:XLEN];
        res_lo = prod[XLEN-1:0];
`ifdef MDU_DIV_EN
        if (is_div) begin
            if (div_zero) begin
                res_hi = rs_raw;
                res_lo = DIV0_LO;
            end else begin
                res_hi = cond_neg32(acc[2*XLEN-1:XLEN], neg_hi);
                res_lo = cond_neg32(acc[XLEN-1:0], neg_lo);
            end
        end
`endif
    end

    // Operand/iteration datapath: not reset, qualified by the FSM.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= {{XLEN{1'b0}}, rt_mag};
            mcand  <= rs_mag;
            neg_lo <= signed_op && (i_rs[XLEN-1] ^ i_rt[XLEN-1]);
`ifdef MDU_DIV_EN
            is_div   <= div_op;
            neg_hi   <= signed_op && i_rs[XLEN-1];
            div_zero <= (i_rt == '0);
            rs_raw   <= i_rs;
            if (div_op) begin
                acc   <= {{XLEN{1'b0}}, rs_mag};
                mcand <= rt_mag;
            end
`endif
        end else if (state == ST_CALC) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_CALC;
                        count <= CNT_LOAD;
                    end else if (i_start && (i_op == OP_MTHI)) begin
                        hi <= i_rs;
                    end else if (i_start && (i_op == OP_MTLO)) begin
                        lo <= i_rs;
                    end
                end
                ST_CALC: begin
                    count <= 5'(count - 5'd1);
                    if (count == 5'd0) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (state == ST_CALC) || (state == ST_COMMIT);
    assign o_done = done;
    assign o_hi   = hi;
    assign o_lo   = lo;

endmodule

// File: tb/tb_single_mdu.sv
// Self-checking bench for single_mdu: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized traffic. Follows MDU_DIV_EN like the RTL.
module tb_single_mdu;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_rs;
    logic [31:0] i_rt;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int checks = 0;
    int errors = 0;

    single_mdu dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_op    (i_op),
        .i_rs    (i_rs),
        .i_rt    (i_rt),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Result {HI, LO} from the instruction definitions, using plain arithmetic.
    function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; return 64'(p); end
            3'd1: begin u = {32'd0, a} * {32'd0, b}; return u; end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    int          m_left = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          m_done = 1'b0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else if (i_start) begin
                if (i_op <= 3'd1 || (DIV_EN && (i_op == 3'd2 || i_op == 3'd3))) begin
                    m_pend = model_res(i_op, i_rs, i_rt);
                    m_left = 33;
                end else if (i_op == 3'd4) begin
                    m_hi = i_rs;
                end else if (i_op == 3'd5) begin
                    m_lo = i_rs;
                end
            end
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", 64'(o_busy), 64'(m_left > 0));
            chk("cyc_done", 64'(o_done), 64'(m_done));
            chk("cyc_hi", 64'(o_hi), 64'(m_hi));
            chk("cyc_lo", 64'(o_lo), 64'(m_lo));
        end
    end

    task automatic launch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        i_start = 1'b1;
        i_op    = op;
        i_rs    = rs;
        i_rt    = rt;
    endtask

    task automatic collect(input int n, output int nbusy, output int ndone);
        @(negedge clk);
        i_start = 1'b0;
        nbusy = 0;
        ndone = 0;
        for (int k = 0; k < n; k++) begin
            if (o_busy) nbusy++;
            if (o_done) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int nbusy, output int ndone);
        @(negedge clk);
        launch(op, rs, rt);
        collect(40, nbusy, ndone);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb, nd, nb2, nd2;
        bit rst_pending;
        rst = 1'b0; i_start = 1'b0; i_op = '0; i_rs = '0; i_rt = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_hi", 64'(o_hi), 64'd0);
        chk("reset_lo", 64'(o_lo), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        #2 rst = 1'b0;

        run_op(3'd4, 32'h0000_1234, 32'd0, nb, nd);
        chk("mthi_busy", 64'(nb), 64'd0);
        chk("mthi_done", 64'(nd), 64'd0);
        chk("mthi_hi", 64'(o_hi), 64'h1234);
        run_op(3'd5, 32'h0000_ABCD, 32'd0, nb, nd);
        chk("mtlo_lo", 64'(o_lo), 64'hABCD);
        chk("mtlo_hi_kept", 64'(o_hi), 64'h1234);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, nb, nd);
        chk("mult_busy_cycles", 64'(nb), 64'd33);
        chk("mult_done_pulses", 64'(nd), 64'd1);
        chk("mult_hi", 64'(o_hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(o_lo), 64'hFFFF_FFFA);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, nd);
        chk("multu_hi", 64'(o_hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(o_lo), 64'h0000_0001);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb, nd);
        chk("div_busy_cycles", 64'(nb), DIV_EN ? 64'd33 : 64'd0);
        chk("div_done_pulses", 64'(nd), DIV_EN ? 64'd1 : 64'd0);
        chk("div_hi", 64'(o_hi), DIV_EN ? 64'hFFFF_FFFF : 64'hFFFF_FFFE);
        chk("div_lo", 64'(o_lo), DIV_EN ? 64'hFFFF_FFFD : 64'h0000_0001);

        run_op(3'd3, 32'd7, 32'd0, nb, nd);
        chk("divu0_busy_cycles", 64'(nb), DIV_EN ? 64'd33 : 64'd0);
        chk("divu0_hi", 64'(o_hi), DIV_EN ? 64'd7 : 64'hFFFF_FFFE);
        chk("divu0_lo", 64'(o_lo), DIV_EN ? 64'hFFFF_FFFF : 64'h0000_0001);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
        chk("div_ovf_hi", 64'(o_hi), DIV_EN ? 64'd0 : 64'hFFFF_FFFE);
        chk("div_ovf_lo", 64'(o_lo), DIV_EN ? 64'h8000_0000 : 64'h0000_0001);

        run_op(3'd6, 32'h5555_5555, 32'd9, nb, nd);
        chk("rsvd_busy", 64'(nb), 64'd0);
        chk("rsvd_done", 64'(nd), 64'd0);
        chk("rsvd_lo_kept", 64'(o_lo), DIV_EN ? 64'h8000_0000 : 64'h0000_0001);

        // Second request mid-calculation must be dropped.
        @(negedge clk);
        launch(3'd0, 32'd6, 32'd7);
        collect(8, nb, nd);
        launch(3'd5, 32'd5, 32'd0);
        collect(40, nb2, nd2);
        chk("busy_ignore_done", 64'(nd + nd2), 64'd1);
        chk("busy_ignore_lo", 64'(o_lo), 64'd42);
        chk("busy_ignore_hi", 64'(o_hi), 64'd0);

        // Abort by reset at cycle 15, then start on the first edge after release.
        @(negedge clk);
        launch(3'd0, 32'd5, 32'd5);
        collect(14, nb, nd);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_done", 64'(o_done), 64'd0);
        chk("abort_hi", 64'(o_hi), 64'd0);
        chk("abort_lo", 64'(o_lo), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 launch(3'd1, 32'd3, 32'd4);
        collect(40, nb, nd);
        chk("post_rst_busy", 64'(nb), 64'd33);
        chk("post_rst_done", 64'(nd), 64'd1);
        chk("post_rst_lo", 64'(o_lo), 64'd12);
        chk("post_rst_hi", 64'(o_hi), 64'd0);

        // Randomized traffic, compared every cycle against the model.
        rst_pending = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (rst_pending) begin
                #2 rst = 1'b0;
                rst_pending = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                rst_pending = 1'b1;
            end
            i_start = ($urandom_range(0, 3) == 0);
            i_op    = 3'($urandom_range(0, 7));
            i_rs    = pick();
            i_rt    = pick();
        end
        @(negedge clk);
        i_start = 1'b0;
        rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
